// File: rtl/result_drain_ctrl.sv
// Purpose: drains rows of partial sums from the result SRAM and streams them to the host as beats.
// Latency: the first beat is valid two cycles after start. Streaming runs bubble-free while out_ready stays high.
// Backpressure: out_ready low holds the current beat. At most 2 rows are buffered or in flight.
// Ports: clk/rst; start, base_addr, row_count (command); sram_address, sram_read_en, sram_data_in (SRAM read port);
//        out_data, out_valid, out_ready, out_row_last, out_last (host stream); busy, done (status).
module result_drain_ctrl #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 32,
  parameter int OUT_SUMS       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [ADDRESSSIZE-1:0]             base_addr,
  input  logic [ADDRESSSIZE:0]               row_count,
  output logic [ADDRESSSIZE-1:0]             sram_address,
  output logic                               sram_read_en,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_in,
  output logic [OUT_SUMS*PARTIAL_SUM_BW-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_row_last,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int ROW_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int BEAT_W = OUT_SUMS * PARTIAL_SUM_BW;
  localparam int BEATS  = MATRIX_SIZE / OUT_SUMS;
  localparam int BW     = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] base_q, base_d;
  logic [ADDRESSSIZE:0]   count_q, count_d;
  logic [ADDRESSSIZE:0]   issued_q, issued_d;
  logic [ADDRESSSIZE:0]   rows_out_q, rows_out_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic                   head_q, head_d;
  logic [1:0]             occ_q, occ_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDRESSSIZE-1:0] rd_addr_q, rd_addr_d;
  logic                   pend_q;              // SRAM data for the previous read is on sram_data_in now
  logic [ROW_W-1:0]       rowbuf_q [2];

  logic       hs;
  logic       pop;
  logic       tail;
  logic [2:0] committed;

  assign out_valid    = (state_q == S_RUN) && (occ_q != 2'd0);
  assign out_data     = rowbuf_q[head_q][beat_q*BEAT_W +: BEAT_W];
  assign out_row_last = out_valid && (beat_q == LAST_BEAT);
  assign out_last     = out_row_last && ((rows_out_q + 1'b1) == count_q);
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign sram_address = rd_addr_q;
  assign sram_read_en = rd_en_q;

  assign hs   = out_valid && out_ready;
  assign pop  = hs && (beat_q == LAST_BEAT);
  // Pushes only happen with occupancy 0 or 1, so the tail is head + occupancy mod 2.
  assign tail = head_q ^ occ_q[0];
  // Buffered rows plus both SRAM pipeline stages; a row being popped this cycle is
  // still counted, which keeps the 2-row bound strict under any backpressure.
  assign committed = {1'b0, occ_q} + {2'b0, rd_en_q} + {2'b0, pend_q};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    rows_out_d = rows_out_q;
    beat_d     = beat_q;
    head_d     = head_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    occ_d      = occ_q + {1'b0, pend_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_count == '0) begin
            state_d = S_DONE;
          end else begin
            // First read goes out in the same cycle as the accept.
            state_d    = S_RUN;
            base_d     = base_addr;
            count_d    = row_count;
            issued_d   = {{ADDRESSSIZE{1'b0}}, 1'b1};
            rows_out_d = '0;
            beat_d     = '0;
            rd_en_d    = 1'b1;
            rd_addr_d  = base_addr;
          end
        end
      end
      S_RUN: begin
        if ((issued_q < count_q) && (committed < 3'd2)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + issued_q[ADDRESSSIZE-1:0];
          issued_d  = issued_q + 1'b1;
        end
        if (hs) begin
          if (beat_q == LAST_BEAT) begin
            beat_d     = '0;
            head_d     = ~head_q;
            rows_out_d = rows_out_q + 1'b1;
            if (out_last) state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      rows_out_q  <= '0;
      beat_q      <= '0;
      head_q      <= 1'b0;
      occ_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      pend_q      <= 1'b0;
      rowbuf_q[0] <= '0;
      rowbuf_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      rows_out_q <= rows_out_d;
      beat_q     <= beat_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      pend_q     <= rd_en_q;
      if (pend_q) rowbuf_q[tail] <= sram_data_in;
    end
  end

endmodule

// File: tb/tb_result_drain_ctrl.sv
module tb_result_drain_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [9:0]    base_addr;
  logic [10:0]   row_count;
  logic [9:0]    sram_address;
  logic          sram_read_en;
  logic [767:0]  sram_data_in;
  logic [95:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_row_last;
  logic          out_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  result_drain_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
    .sram_address(sram_address), .sram_read_en(sram_read_en), .sram_data_in(sram_data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_last(out_row_last), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM contents: sum i of address a is i + 100*(a-4), so address 5 holds 100..131.
  function automatic logic [23:0] sumv(input logic [9:0] a, input int i);
    return 24'(i + 100 * (int'(a) - 4));
  endfunction

  function automatic logic [767:0] mkrow(input logic [9:0] a);
    logic [767:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i*24 +: 24] = sumv(a, i);
    return r;
  endfunction

  function automatic logic [95:0] exp_beat(input logic [9:0] a, input int k);
    logic [95:0] b;
    b = '0;
    for (int j = 0; j < 4; j++) b[j*24 +: 24] = sumv(a, k*4 + j);
    return b;
  endfunction

  // Synchronous-read SRAM: data appears one cycle after the address.
  always @(posedge clk) if (sram_read_en) sram_data_in <= mkrow(sram_address);

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 96'(out_valid), 96'd0);
    chk({tag, "_data"}, out_data, 96'd0);
    chk({tag, "_rowlast"}, 96'(out_row_last), 96'd0);
    chk({tag, "_last"}, 96'(out_last), 96'd0);
    chk({tag, "_rden"}, 96'(sram_read_en), 96'd0);
    chk({tag, "_addr"}, 96'(sram_address), 96'd0);
    chk({tag, "_busy"}, 96'(busy), 96'd0);
    chk({tag, "_done"}, 96'(done), 96'd0);
  endtask

  // Issues start at the current negedge and scoreboards the whole transfer.
  task automatic drain(input logic [9:0] base, input logic [10:0] cnt, input int ready_pct,
                       input bit check_timing, input bit mid_start);
    int c, beats_got, rd_issued, rows_done, first_hs, last_hs, budget, r, k;
    bit got_done, stalled;
    logic [95:0] held_data;
    logic held_rl, held_l;
    logic [95:0] exp;
    c = 0; beats_got = 0; rd_issued = 0; rows_done = 0; first_hs = -1; last_hs = -1;
    got_done = 0; stalled = 0; held_data = '0; held_rl = 0; held_l = 0;
    budget = int'(cnt) * 8 * 20 + 50;
    base_addr = base; row_count = cnt; start = 1'b1;
    while (!got_done && c < budget) begin
      @(negedge clk);
      start = 1'b0;
      if (mid_start && c == 5) begin
        start = 1'b1; base_addr = 10'd7; row_count = 11'd1;
      end
      if (c == 0) chk("busy_after_start", 96'(busy), 96'd1);
      if (stalled) begin
        chk("stall_valid", 96'(out_valid), 96'd1);
        chk("stall_data", out_data, held_data);
        chk("stall_rowlast", 96'(out_row_last), 96'(held_rl));
        chk("stall_last", 96'(out_last), 96'(held_l));
      end
      if (done) begin
        got_done = 1;
        chk("done_busy", 96'(busy), 96'd0);
        chk("beat_total", 96'(beats_got), 96'(int'(cnt) * 8));
        if (check_timing) begin
          chk("first_beat_cycle", 96'(first_hs), 96'd2);
          chk("beats_consecutive", 96'(last_hs - first_hs + 1), 96'(int'(cnt) * 8));
          chk("done_cycle", 96'(c), 96'(last_hs + 1));
        end
      end else begin
        if (sram_read_en) begin
          chk("rd_addr", 96'(sram_address), 96'(10'(base + 10'(rd_issued))));
          rd_issued++;
          checks++;
          assert (rd_issued - rows_done <= 2) else begin
            errors++;
            $error("FAIL rd_outstanding: got %0d expected <=2", rd_issued - rows_done);
          end
        end
        out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
        stalled = out_valid && !out_ready;
        held_data = out_data; held_rl = out_row_last; held_l = out_last;
        if (out_valid && out_ready) begin
          r = beats_got / 8;
          k = beats_got % 8;
          exp = exp_beat(10'(base + 10'(r)), k);
          chk("beat_data", out_data, exp);
          if (base == 10'd5 && beats_got == 0)
            chk("beat0_const", out_data, {24'd103, 24'd102, 24'd101, 24'd100});
          chk("row_last", 96'(out_row_last), 96'(k == 7));
          chk("last", 96'(out_last), 96'(k == 7 && r == int'(cnt) - 1));
          beats_got++;
          if (k == 7) rows_done++;
          if (first_hs < 0) first_hs = c;
          last_hs = c;
        end
        c++;
      end
    end
    chk("drain_completed", 96'(got_done), 96'd1);
    out_ready = 1'b0;
    @(negedge clk);  // let DONE return to IDLE
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0; out_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic drain with exact cycle timing.
    drain(10'd5, 11'd2, 100, 1'b1, 1'b0);

    // Address wrap-around.
    drain(10'd1022, 11'd4, 100, 1'b1, 1'b0);

    // Backpressure at ~30% ready duty.
    drain(10'd100, 11'd8, 30, 1'b0, 1'b0);

    // Zero rows: done next cycle, nothing read, never busy.
    base_addr = 10'd3; row_count = 11'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 96'(done), 96'd1);
    chk("zero_busy", 96'(busy), 96'd0);
    chk("zero_rden", 96'(sram_read_en), 96'd0);
    @(negedge clk);
    chk("zero_done_fall", 96'(done), 96'd0);
    chk("zero_rden2", 96'(sram_read_en), 96'd0);

    // Start pulse in the middle of a transfer is ignored.
    drain(10'd300, 11'd3, 100, 1'b1, 1'b1);

    // Async reset at beat 5 of row 1 (beat 13 is presented 15 cycles after accept).
    base_addr = 10'd10; row_count = 11'd2; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_reset_valid", 96'(out_valid), 96'd1);
    chk("pre_reset_data", out_data, exp_beat(10'd11, 5));
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    drain(10'd20, 11'd1, 100, 1'b1, 1'b0);

    // Whole memory.
    drain(10'd0, 11'd1024, 100, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
